vrf_wb_sequencer: RTL and testbench

Write-back stage directly upstream of the VRF write port. It accepts one parallel result group from the execution lanes (one element per lane, plus a per-element write mask), buffers it, and serialises it into the VRF's single-element write port. It drives the VRF write handshake (request, per-element enable, element index, last-element ready) and reports pending/done destination-register status to issue logic for hazard tracking.

---
 rtl/vrf_wb_sequencer_if.sv | 42 ++++
 rtl/vrf_wb_sequencer.sv | 87 ++++++++
 tb/tb_vrf_wb_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vrf_wb_sequencer_if.sv
// vrf_wb_sequencer_if: bundle carrying one parallel result group into the
// write-back sequencer and the serialised VRF write port plus the
// pending/done hazard status back out.
//   res_*  : result group handshake from the execution lanes
//   wr_*   : single-element VRF write port (request, enable, last, address, index, data)
//   pend_* : destination of the group currently buffered or being written
//   wb_done_* : one-cycle completion pulse with the finished destination
//   slave  : seen from the sequencer; master : seen from the driver of results
interface vrf_wb_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4
);
  localparam int ADDR_B = $clog2(REG_NUM);
  localparam int ELEM_B = $clog2(LANES);
  logic                        res_valid_i;
  logic                        res_ready_o;
  logic [LANES*DATA_WIDTH-1:0] res_data_i;
  logic [LANES-1:0]            res_mask_i;
  logic [ELEM_B:0]             res_nelem_i;
  logic [ADDR_B-1:0]           res_vd_i;
  logic                        wr_req_o;
  logic                        wr_en_o;
  logic                        wr_ready_o;
  logic [ADDR_B-1:0]           wr_addr_o;
  logic [ELEM_B-1:0]           wr_elem_cnt_o;
  logic [DATA_WIDTH-1:0]       wdata_o;
  logic                        pend_valid_o;
  logic [ADDR_B-1:0]           pend_vd_o;
  logic                        wb_done_o;
  logic [ADDR_B-1:0]           wb_done_vd_o;
  modport slave (
    input  res_valid_i, res_data_i, res_mask_i, res_nelem_i, res_vd_i,
    output res_ready_o, wr_req_o, wr_en_o, wr_ready_o, wr_addr_o, wr_elem_cnt_o,
           wdata_o, pend_valid_o, pend_vd_o, wb_done_o, wb_done_vd_o
  );
  modport master (
    output res_valid_i, res_data_i, res_mask_i, res_nelem_i, res_vd_i,
    input  res_ready_o, wr_req_o, wr_en_o, wr_ready_o, wr_addr_o, wr_elem_cnt_o,
           wdata_o, pend_valid_o, pend_vd_o, wb_done_o, wb_done_vd_o
  );
endinterface

// File: rtl/vrf_wb_sequencer.sv
// vrf_wb_sequencer: buffers one parallel result group and serialises it into
// the single-element VRF write port, reporting pending/done destinations.
//   clk_i    : clock
//   resetn_i : asynchronous active-low reset
//   bus      : result group in, VRF write port and hazard status out
module vrf_wb_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4
) (
  input logic                clk_i,
  input logic                resetn_i,
  vrf_wb_sequencer_if.slave  bus
);
  localparam int ADDR_B = $clog2(REG_NUM);
  localparam int ELEM_B = $clog2(LANES);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WR} state_t;
  state_t                            state_q, state_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]  data_q, data_d;
  logic [LANES-1:0]                  mask_q, mask_d, eff_mask;
  logic [ADDR_B-1:0]                 vd_q, vd_d, done_vd_q, done_vd_d, defer_vd_q, defer_vd_d, first_vd;
  logic [ELEM_B-1:0]                 last_q, last_d, cnt_q, cnt_d, eff_last;
  logic [ELEM_B:0]                   eff_n;
  logic                              done_q, done_d, defer_q, defer_d;
  logic                              fin, accept, drop, load, first_vld;
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      mask_q     <= '0;
      vd_q       <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      done_vd_q  <= '0;
      defer_q    <= 1'b0;
      defer_vd_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      vd_q       <= vd_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      done_vd_q  <= done_vd_d;
      defer_q    <= defer_d;
      defer_vd_q <= defer_vd_d;
    end
  always_comb begin
    eff_n = (bus.res_nelem_i == '0 || bus.res_nelem_i > (ELEM_B+1)'(LANES)) ? (ELEM_B+1)'(LANES) : bus.res_nelem_i;
    eff_last = ELEM_B'(eff_n - 1'b1);
    eff_mask = '0;
    for (int i = 0; i < LANES; i++) eff_mask[i] = bus.res_mask_i[i] && ((ELEM_B+1)'(i) < eff_n);
    fin = state_q == S_WR && cnt_q == last_q;
    accept = bus.res_valid_i && (state_q == S_IDLE || fin);
    drop = accept && eff_mask == '0;
    load = accept && !drop;
    state_d = (state_q == S_REQ || (state_q == S_WR && !fin)) ? S_WR : load ? S_REQ : S_IDLE;
    cnt_d = (state_q == S_WR && !fin) ? cnt_q + 1'b1 : '0;
    data_d = load ? bus.res_data_i : data_q;
    mask_d = load ? eff_mask : mask_q;
    vd_d = load ? bus.res_vd_i : vd_q;
    last_d = load ? eff_last : last_q;
    // A drop accepted in the same cycle a written group finishes would need two
    // done pulses at once; the drop's pulse is deferred one cycle instead.
    first_vld = fin || defer_q;
    first_vd = fin ? vd_q : defer_vd_q;
    done_d = first_vld || drop;
    done_vd_d = first_vld ? first_vd : drop ? bus.res_vd_i : done_vd_q;
    defer_d = first_vld && drop;
    defer_vd_d = defer_d ? bus.res_vd_i : defer_vd_q;
  end
  always_comb begin
    bus.res_ready_o   = state_q == S_IDLE || fin;
    bus.wr_req_o      = state_q == S_REQ;
    bus.wr_en_o       = state_q == S_WR && mask_q[cnt_q];
    bus.wr_ready_o    = fin;
    bus.wr_addr_o     = state_q != S_IDLE ? vd_q : '0;
    bus.wr_elem_cnt_o = state_q == S_WR ? cnt_q : '0;
    bus.wdata_o       = state_q == S_WR ? data_q[cnt_q] : '0;
    bus.pend_valid_o  = state_q != S_IDLE;
    bus.pend_vd_o     = state_q != S_IDLE ? vd_q : '0;
    bus.wb_done_o     = done_q;
    bus.wb_done_vd_o  = done_vd_q;
  end
endmodule

// File: tb/tb_vrf_wb_sequencer.sv
// tb_vrf_wb_sequencer: directed and random result groups checked cycle by cycle against a transaction-level model.
module tb_vrf_wb_sequencer;
  typedef struct packed {
    logic        req;
    logic        en;
    logic        rdy;
    logic [4:0]  addr;
    logic [1:0]  elem;
    logic [31:0] data;
  } entry_t;
  logic clk_i = 1'b0;
  logic resetn_i = 1'b0;
  int passed = 0;
  int total = 0;
  entry_t exp_q[$];
  logic [4:0] done_q[$];
  logic exp_done = 1'b0;
  logic [4:0] exp_done_vd = '0;
  logic acc, acc2;
  vrf_wb_sequencer_if #(.DATA_WIDTH(32), .REG_NUM(32), .LANES(4)) bus ();
  vrf_wb_sequencer #(.DATA_WIDTH(32), .REG_NUM(32), .LANES(4)) dut (
    .clk_i(clk_i),
    .resetn_i(resetn_i),
    .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic check_outs();
    entry_t e;
    e = exp_q.size() != 0 ? exp_q[0] : '0;
    chk("res_ready", 32'(bus.res_ready_o), 32'(exp_q.size() == 0 || e.rdy));
    chk("wr_req", 32'(bus.wr_req_o), 32'(e.req));
    chk("wr_en", 32'(bus.wr_en_o), 32'(e.en));
    chk("wr_ready", 32'(bus.wr_ready_o), 32'(e.rdy));
    chk("wr_addr", 32'(bus.wr_addr_o), 32'(e.addr));
    chk("wr_elem_cnt", 32'(bus.wr_elem_cnt_o), 32'(e.elem));
    chk("wdata", bus.wdata_o, e.data);
    chk("pend_valid", 32'(bus.pend_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("pend_vd", 32'(bus.pend_vd_o), 32'(e.addr));
    chk("wb_done", 32'(bus.wb_done_o), 32'(exp_done));
    if (exp_done) chk("wb_done_vd", 32'(bus.wb_done_vd_o), 32'(exp_done_vd));
  endtask
  task automatic step(input logic v, input logic [127:0] d, input logic [3:0] m,
                      input logic [2:0] ne, input logic [4:0] vd, output logic accepted);
    entry_t e, w;
    logic [3:0] em;
    int n;
    @(negedge clk_i);
    bus.res_valid_i = v;
    bus.res_data_i = d;
    bus.res_mask_i = m;
    bus.res_nelem_i = ne;
    bus.res_vd_i = vd;
    check_outs();
    e = exp_q.size() != 0 ? exp_q[0] : '0;
    accepted = v && (exp_q.size() == 0 || e.rdy);
    @(posedge clk_i);
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      if (e.rdy) done_q.push_back(e.addr);
    end
    if (accepted) begin
      n = (ne == 0 || ne > 4) ? 4 : int'(ne);
      em = m & 4'((1 << n) - 1);
      if (em != 0) begin
        w = '0;
        w.req = 1'b1;
        w.addr = vd;
        exp_q.push_back(w);
        for (int i = 0; i < n; i++) begin
          w = '0;
          w.en = em[i];
          w.rdy = (i == n - 1);
          w.addr = vd;
          w.elem = 2'(i);
          w.data = d[i*32 +: 32];
          exp_q.push_back(w);
        end
      end else done_q.push_back(vd);
    end
    exp_done = done_q.size() != 0;
    if (exp_done) exp_done_vd = done_q.pop_front();
  endtask
  task automatic idle(input int k);
    logic a;
    repeat (k) step(1'b0, '0, 4'h0, 3'd0, 5'd0, a);
  endtask
  initial begin
    bus.res_valid_i = 1'b0;
    bus.res_data_i = '0;
    bus.res_mask_i = '0;
    bus.res_nelem_i = '0;
    bus.res_vd_i = '0;
    #1;
    check_outs();
    chk("rst_done_vd", 32'(bus.wb_done_vd_o), 32'd0);
    chk("rst_pend_vd", 32'(bus.pend_vd_o), 32'd0);
    repeat (2) @(negedge clk_i);
    resetn_i = 1'b1;
    idle(2);
    step(1'b1, {32'h13, 32'h12, 32'h11, 32'h10}, 4'b1111, 3'd4, 5'd5, acc);
    idle(8);
    step(1'b1, {32'hd, 32'hc, 32'hb, 32'ha}, 4'b0101, 3'd4, 5'd9, acc);
    idle(7);
    step(1'b1, {32'h23, 32'h22, 32'h21, 32'h20}, 4'b1111, 3'd2, 5'd11, acc);
    idle(5);
    step(1'b1, {32'h33, 32'h32, 32'h31, 32'h30}, 4'b1111, 3'd0, 5'd12, acc);
    idle(7);
    step(1'b1, {32'h43, 32'h42, 32'h41, 32'h40}, 4'b0000, 3'd4, 5'd14, acc);
    idle(2);
    step(1'b1, {32'h53, 32'h52, 32'h51, 32'h50}, 4'b1100, 3'd2, 5'd15, acc);
    idle(2);
    step(1'b1, {32'h63, 32'h62, 32'h61, 32'h60}, 4'b1111, 3'd4, 5'd3, acc);
    acc2 = 1'b0;
    for (int k = 0; k < 20 && !acc2; k++)
      step(1'b1, {32'h73, 32'h72, 32'h71, 32'h70}, 4'b1111, 3'd4, 5'd7, acc2);
    chk("b2b_accepted", 32'(acc2), 32'd1);
    idle(8);
    step(1'b1, {32'h83, 32'h82, 32'h81, 32'h80}, 4'b1111, 3'd4, 5'd9, acc);
    idle(2);
    @(negedge clk_i);
    check_outs();
    #2 resetn_i = 1'b0;
    #1;
    chk("arst_ready", 32'(bus.res_ready_o), 32'd1);
    chk("arst_wr_req", 32'(bus.wr_req_o), 32'd0);
    chk("arst_wr_en", 32'(bus.wr_en_o), 32'd0);
    chk("arst_wr_ready", 32'(bus.wr_ready_o), 32'd0);
    chk("arst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
    chk("arst_elem", 32'(bus.wr_elem_cnt_o), 32'd0);
    chk("arst_wdata", bus.wdata_o, 32'd0);
    chk("arst_pend", 32'(bus.pend_valid_o), 32'd0);
    chk("arst_pend_vd", 32'(bus.pend_vd_o), 32'd0);
    chk("arst_done", 32'(bus.wb_done_o), 32'd0);
    chk("arst_done_vd", 32'(bus.wb_done_vd_o), 32'd0);
    exp_q.delete();
    done_q.delete();
    exp_done = 1'b0;
    exp_done_vd = '0;
    @(negedge clk_i);
    resetn_i = 1'b1;
    idle(6);
    repeat (400)
      step($urandom_range(0, 9) < 7, {$urandom, $urandom, $urandom, $urandom},
           4'($urandom), 3'($urandom), 5'($urandom), acc);
    idle(8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
